car_park_monitor: RTL
=====================

# car_park_monitor

Occupancy monitor for the two-sensor car park gate. Decodes the `a`/`b` photo-sensor sequence into entry and exit events, keeps a saturating occupancy count, and flags full/empty, overflow, underflow and illegal sensor sequences. It is the design-under-test driven by the existing car park stimulus generator. Its `inc`/`dec` pulses are compared against that generator's `inc_exp`/`dec_exp`.

## Interface
- `CAPACITY`, default 15: maximum occupancy; requires `CAPACITY < 2**COUNT_W`.
- `COUNT_W`, default 4: width of `count`.
- `SYNC_STAGES`, default 2: synchroniser depth on `a`/`b`; must be ≥1.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `a` in 1: outer sensor, 1 = beam blocked.
- `b` in 1: inner sensor, 1 = beam blocked.
- `inc` out 1: one-cycle pulse, entry completed.
- `dec` out 1: one-cycle pulse, exit completed.
- `count` out COUNT_W: current occupancy.
- `full` out 1: high when `count == CAPACITY`.
- `empty` out 1: high when `count == 0`.
- `overflow` out 1: one-cycle pulse, entry while full.
- `underflow` out 1: one-cycle pulse, exit while empty.
- `err` out 1: one-cycle pulse, illegal sensor transition.

## Operation
- `a` and `b` each pass through `SYNC_STAGES` flops. The synchronised pair `s = {a_s, b_s}` feeds the FSM.
- States: `IDLE`, `EN1`, `EN2`, `EN3`, `EX1`, `EX2`, `EX3`. The expected sensor value per state is:
  - `EN1` = 10, `EN2` = 11, `EN3` = 01
  - `EX1` = 01, `EX2` = 11, `EX3` = 10
- `IDLE` transitions:
  - 00: stay.
  - 10: go to `EN1`.
  - 01: go to `EX1`.
  - 11: stay in `IDLE` and pulse `err`.
- Rules inside any sequence state:
  - s equals the state's own value: hold.
  - s equals the next step's value: advance.
  - s equals the previous step's value: back up one state (vehicle reversing).
  - 00 from `EN1` or `EX1`: return to `IDLE` silently (vehicle aborted).
  - 00 from `EN3`: go to `IDLE` and pulse `inc`.
  - 00 from `EX3`: go to `IDLE` and pulse `dec`.
  - Any other value: go to `IDLE` and pulse `err`.
- Count updates:
  - `inc` with `count < CAPACITY`: `count + 1`.
  - `inc` with `count == CAPACITY`: count holds and `overflow` pulses.
  - `dec` with `count > 0`: `count - 1`.
  - `dec` with `count == 0`: count holds and `underflow` pulses.
  - `inc`/`dec` themselves always pulse; the count never wraps.
- `inc` and `dec` are mutually exclusive by construction. `err` never coincides with either.
- `full` and `empty` are registered and track `count` in the same cycle.
- Reset values: state `IDLE`, synchroniser flops 0, `count` 0, `empty` 1. `full`, `inc`, `dec`, `overflow`, `underflow` and `err` are all 0.
- Reset asserted mid-sequence discards the sequence and clears the count; no pulse is produced.

## Timing
- Sensor change from the stimulus is applied 2 ns after edge k. The synchroniser captures it at edge k+1, and the FSM acts on it at edge k+SYNC_STAGES+1.
  - With the default, `inc`/`dec` rise after edge k+3 for a 00 applied after edge k.
- All pulses are exactly one clock wide.
- `count`, `full` and `empty` change on the same edge that raises `inc`/`dec`/`overflow`/`underflow`.
- Minimum legal transaction is 4 sensor samples (e.g. 10, 11, 01, 00). Back-to-back transactions with no extra 00 cycle are supported.
- All outputs are registered; there is no combinational path from `a`/`b` to any output.

## Structure
- `car_park_pkg` holds:
  - the state encoding as localparams (3-bit);
  - the sensor encodings `S_CLEAR`=00, `S_OUTER`=10, `S_BOTH`=11, `S_INNER`=01.
- Sub-module `sensor_sync`: parameterised N-flop synchroniser, 1 bit wide, instantiated once each for `a` and `b`, with async active-low reset to 0.
- Top module contains the FSM, the saturating counter and the flag registers.

## Test plan
- Reset, then 5 entries (10, 11, 01, 00 each): 5 `inc` pulses, each 3 cycles after the 00 is applied; `count`=5; `empty` drops after the first entry.
- Continue with 3 exits (01, 11, 10, 00): 3 `dec` pulses; `count`=2; no `err`.
- Reset, then 17 entries: `count`=15; `full`=1 after the 15th entry; `overflow` pulses on entries 16 and 17 while `inc` still pulses.
- Reset, 4 entries, then 8 exits: `count`=0 and `empty`=1 after exit 4; `underflow` pulses on exits 5–8.
- Reverse and abort cases:
  - 10, 11, 10, 00 gives no `inc`; count unchanged.
  - 10 then 01 pulses `err`; FSM returns to `IDLE`.
  - 11 from `IDLE` pulses `err`.
- Reset asserted while in `EN2` with `count`=3: outputs are at reset values immediately, without waiting for a clock edge. A following full entry then gives `count`=1.

Source files
------------

// File: rtl/car_park_pkg.sv
// Shared encodings and the sensor-sequence decoder for the car park monitor.
package car_park_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EN1  = 3'd1;
  localparam logic [2:0] ST_EN2  = 3'd2;
  localparam logic [2:0] ST_EN3  = 3'd3;
  localparam logic [2:0] ST_EX1  = 3'd4;
  localparam logic [2:0] ST_EX2  = 3'd5;
  localparam logic [2:0] ST_EX3  = 3'd6;

  // Sensor pair {a, b}, 1 = beam blocked
  localparam logic [1:0] S_CLEAR = 2'b00;
  localparam logic [1:0] S_OUTER = 2'b10;
  localparam logic [1:0] S_BOTH  = 2'b11;
  localparam logic [1:0] S_INNER = 2'b01;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    EN1  = ST_EN1,
    EN2  = ST_EN2,
    EN3  = ST_EN3,
    EX1  = ST_EX1,
    EX2  = ST_EX2,
    EX3  = ST_EX3
  } state_t;

  // One decoder step: next state plus the event it raises
  typedef struct packed {
    state_t nxt;
    logic   inc;
    logic   dec;
    logic   err;
  } step_t;

  // Entry walks 10 -> 11 -> 01 -> 00, exit walks the mirror image.
  // Own value holds, next value advances, previous value backs up;
  // anything else is an illegal jump and drops back to IDLE with err.
  function automatic step_t fsm_step(state_t st, logic [1:0] s);
    step_t r;
    r.nxt = IDLE;
    r.inc = 1'b0;
    r.dec = 1'b0;
    r.err = 1'b0;
    case (st)
      IDLE: begin
        case (s)
          S_OUTER: r.nxt = EN1;
          S_INNER: r.nxt = EX1;
          S_BOTH:  r.err = 1'b1;
          default: r.nxt = IDLE;
        endcase
      end
      EN1: begin
        case (s)
          S_OUTER: r.nxt = EN1;
          S_BOTH:  r.nxt = EN2;
          S_CLEAR: r.nxt = IDLE;
          default: r.err = 1'b1;
        endcase
      end
      EN2: begin
        case (s)
          S_BOTH:  r.nxt = EN2;
          S_INNER: r.nxt = EN3;
          S_OUTER: r.nxt = EN1;
          default: r.err = 1'b1;
        endcase
      end
      EN3: begin
        case (s)
          S_INNER: r.nxt = EN3;
          S_CLEAR: r.inc = 1'b1;
          S_BOTH:  r.nxt = EN2;
          default: r.err = 1'b1;
        endcase
      end
      EX1: begin
        case (s)
          S_INNER: r.nxt = EX1;
          S_BOTH:  r.nxt = EX2;
          S_CLEAR: r.nxt = IDLE;
          default: r.err = 1'b1;
        endcase
      end
      EX2: begin
        case (s)
          S_BOTH:  r.nxt = EX2;
          S_OUTER: r.nxt = EX3;
          S_INNER: r.nxt = EX1;
          default: r.err = 1'b1;
        endcase
      end
      EX3: begin
        case (s)
          S_OUTER: r.nxt = EX3;
          S_CLEAR: r.dec = 1'b1;
          S_BOTH:  r.nxt = EX2;
          default: r.err = 1'b1;
        endcase
      end
      default: r.nxt = IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sensor_sync.sv
// N-flop, 1-bit synchroniser for an asynchronous photo-sensor input.
module sensor_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sr;

  generate
    if (N == 1) begin : g_single
      // Single capture flop
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) sr <= 1'b0;
        else        sr <= d;
      end
    end else begin : g_chain
      // Shift chain, oldest sample at the top bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[N-2:0], d};
      end
    end
  endgenerate

  assign q = sr[N-1];

endmodule

// File: rtl/car_park_monitor.sv
// Car park gate monitor: decodes a/b sensor sequences into entry/exit
// events and keeps a saturating occupancy count with status flags.
module car_park_monitor
  import car_park_pkg::*;
#(
  parameter int CAPACITY    = 15,
  parameter int COUNT_W     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  output logic               inc,
  output logic               dec,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow,
  output logic               err
);

  localparam logic [COUNT_W-1:0] CAP = COUNT_W'(CAPACITY);

  logic               a_s, b_s;
  state_t             state;
  step_t              step;
  logic [COUNT_W-1:0] cnt_nxt;
  logic               ovf_nxt, unf_nxt;

  sensor_sync #(.N(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .rst_n (reset),
    .d     (a),
    .q     (a_s)
  );

  sensor_sync #(.N(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .rst_n (reset),
    .d     (b),
    .q     (b_s)
  );

  // Decode the synchronised sensor pair against the current state
  always_comb begin
    step = fsm_step(state, {a_s, b_s});
  end

  // Saturating next count; overflow/underflow replace the wrap
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    cnt_nxt = count;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (step.inc) begin
      if (count == CAP) ovf_nxt = 1'b1;
      else              cnt_nxt = count + 1'b1;
    end else if (step.dec) begin
      if (count == '0)  unf_nxt = 1'b1;
      else              cnt_nxt = count - 1'b1;
    end
  end

  // Sequence FSM with registered event pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      inc   <= 1'b0;
      dec   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= step.nxt;
      inc   <= step.inc;
      dec   <= step.dec;
      err   <= step.err;
    end
  end

  // Occupancy counter and flags, updated on the same edge as the pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= cnt_nxt;
      full      <= (cnt_nxt == CAP);
      empty     <= (cnt_nxt == '0);
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

endmodule
